// File: rtl/ofdm_adc_capture.sv
// OFDM ADC capture: registers the 14-bit I/Q rails, keeps 1 of (decim+1) samples,
// packs them into 32-bit words and streams one Avalon-ST packet out of a show-ahead FIFO.
module ofdm_adc_capture #(
  parameter int ADC_W      = 14,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [ADC_W-1:0] adc_RealData,
  input  logic signed [ADC_W-1:0] adc_ImagData,
  input  logic                    ctrl_start,
  input  logic [CNT_W-1:0]        ctrl_length,
  input  logic [3:0]              ctrl_decim,
  output logic                    status_busy,
  output logic                    status_done,
  output logic                    status_overflow,
  output logic [31:0]             src_data,
  output logic                    src_valid,
  input  logic                    src_ready,
  output logic                    src_startofpacket,
  output logic                    src_endofpacket
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = 34;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  function automatic logic signed [15:0] sext16(input logic signed [ADC_W-1:0] x);
    return 16'(x);
  endfunction

  state_t                  state;
  logic signed [ADC_W-1:0] ri_p0;
  logic signed [ADC_W-1:0] rq_p0;
  logic [CNT_W-1:0]        len_l;
  logic [CNT_W-1:0]        sample_cnt;
  logic [3:0]              decim_l;
  logic [3:0]              dcnt;
  logic                    sop_pending;

  logic [FW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;
  logic [FW-1:0]           data_p2;
  logic                    vld_p2;

  logic                    keep;
  logic                    full;
  logic                    last_kept;
  logic                    wr_en;
  logic                    pop;
  logic                    load;
  logic [AW-1:0]           rd_idx;
  logic [FW-1:0]           wr_word;

  // Stage p0: ADC rails registered every cycle, regardless of state
  always_ff @(posedge clk) begin
    ri_p0 <= adc_RealData;
    rq_p0 <= adc_ImagData;
  end

  // Stage p1: decimation/keep decision and FIFO write
  always_comb begin
    keep      = (state == CAPTURE) && (dcnt == 4'd0);
    full      = (count == (AW+1)'(FIFO_DEPTH));
    wr_en     = keep && !full;
    last_kept = keep && (sample_cnt == len_l - CNT_W'(1));
    wr_word   = {sext16(ri_p0), sext16(rq_p0), sop_pending, last_kept};
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  // Stage p2: show-ahead output register; the shown head stays counted until it transfers
  always_comb begin
    pop    = vld_p2 && src_ready;
    load   = (!vld_p2 && (count != '0)) || (pop && (count > (AW+1)'(1)));
    rd_idx = pop ? rd_ptr + AW'(1) : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_p2 <= '0;
    end else if (load) begin
      data_p2 <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_p2 <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (load)     vld_p2 <= 1'b1;
      else if (pop) vld_p2 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      status_busy     <= 1'b0;
      status_done     <= 1'b0;
      status_overflow <= 1'b0;
      len_l           <= '0;
      decim_l         <= '0;
      dcnt            <= '0;
      sample_cnt      <= '0;
      sop_pending     <= 1'b0;
    end else begin
      status_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_start && (ctrl_length != '0)) begin
            len_l           <= ctrl_length;
            decim_l         <= ctrl_decim;
            status_overflow <= 1'b0;
            dcnt            <= '0;
            sample_cnt      <= '0;
            sop_pending     <= 1'b1;
            status_busy     <= 1'b1;
            state           <= CAPTURE;
          end
        end
        CAPTURE: begin
          dcnt <= (dcnt == decim_l) ? 4'd0 : dcnt + 4'd1;
          if (keep) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            // A dropped first sample keeps SOP pending for the next written one
            if (!full) sop_pending     <= 1'b0;
            else       status_overflow <= 1'b1;
          end
          if (last_kept) state <= DRAIN;
        end
        DRAIN: begin
          if ((count == '0) && !vld_p2) begin
            status_done <= 1'b1;
            status_busy <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          status_busy <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign src_data          = data_p2[33:2];
  assign src_startofpacket = data_p2[1];
  assign src_endofpacket   = data_p2[0];
  assign src_valid         = vld_p2;

endmodule

// File: tb/tb_ofdm_adc_capture.sv
// Scoreboard bench for ofdm_adc_capture: directed captures push expected beats,
// a negedge monitor pops and compares every transferred beat.
module tb_ofdm_adc_capture;

  localparam int ADC_W = 14;
  localparam int FIFO_DEPTH = 64;
  localparam int CNT_W = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic signed [ADC_W-1:0] adc_RealData;
  logic signed [ADC_W-1:0] adc_ImagData;
  logic                    ctrl_start;
  logic [CNT_W-1:0]        ctrl_length;
  logic [3:0]              ctrl_decim;
  logic                    status_busy;
  logic                    status_done;
  logic                    status_overflow;
  logic [31:0]             src_data;
  logic                    src_valid;
  logic                    src_ready;
  logic                    src_startofpacket;
  logic                    src_endofpacket;

  ofdm_adc_capture #(.ADC_W(ADC_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .adc_RealData(adc_RealData),
    .adc_ImagData(adc_ImagData),
    .ctrl_start(ctrl_start),
    .ctrl_length(ctrl_length),
    .ctrl_decim(ctrl_decim),
    .status_busy(status_busy),
    .status_done(status_done),
    .status_overflow(status_overflow),
    .src_data(src_data),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_startofpacket(src_startofpacket),
    .src_endofpacket(src_endofpacket)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int ready_mode = 1;
  int rcyc = 0;
  logic [33:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // src_ready driver: 0 = always ready, 1 = never ready, 2 = fixed stall pattern
  initial begin
    src_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      case (ready_mode)
        0:       src_ready = 1'b1;
        1:       src_ready = 1'b0;
        default: src_ready = ((rcyc % 4) != 1);
      endcase
    end
  end

  // Scoreboard monitor plus hold-while-stalled and done-pulse checks
  logic        prev_stall = 1'b0;
  logic        prev_done = 1'b0;
  logic [33:0] prev_word = '0;
  always @(negedge clk) begin
    logic [33:0] e;
    if (prev_stall) begin
      check("stall_valid_hold", 32'(src_valid), 32'd1);
      check("stall_data_hold", src_data, prev_word[33:2]);
      check("stall_flag_hold", 32'({src_startofpacket, src_endofpacket}), 32'(prev_word[1:0]));
    end
    if (!reset && src_valid && src_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", src_data, e[33:2]);
        check("beat_sop", 32'(src_startofpacket), 32'(e[1]));
        check("beat_eop", 32'(src_endofpacket), 32'(e[0]));
      end
    end
    if (prev_done) check("done_pulse_width", 32'(status_done), 32'd0);
    if (status_done) begin
      done_cnt++;
      check("busy_low_with_done", 32'(status_busy), 32'd0);
    end
    prev_done  = status_done;
    prev_stall = !reset && src_valid && !src_ready;
    prev_word  = {src_data, src_startofpacket, src_endofpacket};
  end

  // Ramp I = i, Q = -i; start on the first cycle; the first `stored` kept samples are expected
  task automatic ramp_run(input int len, input int dec, input int stored, input int ncyc,
                          input bit restart);
    int v;
    for (int k = 0; k < len && k < stored; k++) begin
      v = k * (dec + 1);
      exp_q.push_back({16'(v), 16'(-v), (k == 0), (k == len - 1)});
    end
    for (int i = 0; i < ncyc; i++) begin
      adc_RealData = ADC_W'(i);
      adc_ImagData = ADC_W'(-i);
      ctrl_start   = (i == 0) || (restart && i == 2);
      ctrl_length  = (i == 0) ? CNT_W'(len) : CNT_W'(8);
      ctrl_decim   = 4'(dec);
      step();
      if (i == 0) check("busy_after_start", 32'(status_busy), 32'(len != 0));
    end
    ctrl_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (status_busy && c < budget) begin
      step();
      c++;
    end
    check("idle_within_budget", 32'(status_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset = 1'b1;
    adc_RealData = '0;
    adc_ImagData = '0;
    ctrl_start = 1'b0;
    ctrl_length = '0;
    ctrl_decim = '0;
    repeat (3) step();
    check("rst_valid", 32'(src_valid), 32'd0);
    check("rst_data", src_data, 32'd0);
    check("rst_sop_eop", 32'({src_startofpacket, src_endofpacket}), 32'd0);
    check("rst_status", 32'({status_busy, status_done, status_overflow}), 32'd0);
    reset = 1'b0;
    ready_mode = 0;
    step();

    // Basic capture, with a second start while busy that must be ignored
    d0 = done_cnt;
    ramp_run(4, 0, 4, 14, 1'b1);
    wait_idle(100);
    repeat (4) step();
    check("basic_done_count", 32'(done_cnt - d0), 32'd1);
    check("basic_queue_empty", 32'(exp_q.size()), 32'd0);

    // Sign extension of the 14-bit rails
    d0 = done_cnt;
    exp_q.push_back({32'hE000_1FFF, 1'b1, 1'b1});
    adc_RealData = 14'h2000;
    adc_ImagData = 14'h1FFF;
    ctrl_start = 1'b1;
    ctrl_length = 16'd1;
    ctrl_decim = 4'd0;
    step();
    ctrl_start = 1'b0;
    wait_idle(100);
    repeat (3) step();
    check("sext_done_count", 32'(done_cnt - d0), 32'd1);
    check("sext_queue_empty", 32'(exp_q.size()), 32'd0);

    // Decimation by 3: kept I values 0, 3, 6
    d0 = done_cnt;
    ramp_run(3, 2, 3, 12, 1'b0);
    wait_idle(100);
    repeat (3) step();
    check("decim_done_count", 32'(done_cnt - d0), 32'd1);
    check("decim_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure into overflow: only FIFO_DEPTH samples survive, no EOP
    d0 = done_cnt;
    ready_mode = 1;
    step();
    ramp_run(FIFO_DEPTH + 5, 0, FIFO_DEPTH, FIFO_DEPTH + 8, 1'b0);
    check("ovf_sticky", 32'(status_overflow), 32'd1);
    check("ovf_busy_in_drain", 32'(status_busy), 32'd1);
    check("ovf_valid_held", 32'(src_valid), 32'd1);
    check("ovf_no_done_yet", 32'(done_cnt - d0), 32'd0);
    ready_mode = 0;
    wait_idle(400);
    repeat (3) step();
    check("ovf_done_count", 32'(done_cnt - d0), 32'd1);
    check("ovf_queue_empty", 32'(exp_q.size()), 32'd0);

    // Stalled drain of a 100-sample packet; overflow must be cleared by the new start
    d0 = done_cnt;
    ready_mode = 2;
    ramp_run(100, 0, 100, 104, 1'b0);
    wait_idle(400);
    repeat (3) step();
    check("stall_overflow_clear", 32'(status_overflow), 32'd0);
    check("stall_done_count", 32'(done_cnt - d0), 32'd1);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    ready_mode = 0;

    // Zero-length start is ignored
    d0 = done_cnt;
    ramp_run(0, 0, 0, 6, 1'b0);
    check("len0_no_busy", 32'(status_busy), 32'd0);
    check("len0_no_done", 32'(done_cnt - d0), 32'd0);

    // Reset in the middle of a capture discards everything
    ready_mode = 1;
    step();
    ramp_run(50, 0, 0, 10, 1'b0);
    reset = 1'b1;
    step();
    check("midrst_valid", 32'(src_valid), 32'd0);
    check("midrst_busy", 32'(status_busy), 32'd0);
    check("midrst_overflow", 32'(status_overflow), 32'd0);
    reset = 1'b0;
    ready_mode = 0;
    d0 = done_cnt;
    repeat (6) step();
    check("midrst_fifo_empty", 32'(src_valid), 32'd0);
    check("midrst_idle", 32'(status_busy), 32'd0);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    // Recovery after reset
    ramp_run(4, 0, 4, 8, 1'b0);
    wait_idle(100);
    repeat (3) step();
    check("recover_done_count", 32'(done_cnt - d0), 32'd1);
    check("recover_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
